// File: rtl/param_wave_gen.sv
// ---------------------------------------------------------------------------
// param_wave_gen
//
// Streaming waveform generator. A phase accumulator advances by 'step' on
// every accepted sample strobe. The top bits of the phase are shaped into a
// square, triangle, ramp-up, ramp-down or rectified-triangle sample. That
// sample is amplitude-scaled and presented behind a valid/ready handshake.
// Mode, duty and amplitude requests take effect only when the phase wraps,
// so a running period is never cut short by a configuration change.
//
// Parameters:
//   W   sample width; also the width of duty and amp
//   PW  phase accumulator / step width (PW >= W+1)
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   en         generator enable (config follows inputs while low)
//   clr        synchronous phase clear, overrides sample loading
//   tick       sample-rate strobe
//   sel        waveform mode request
//   step       phase increment per sample (not shadowed)
//   duty       square-wave threshold request
//   amp        amplitude request (all-ones = unity gain)
//   out_data   registered sample
//   out_valid  sample valid
//   out_ready  sink accepts sample
//   out_last   final sample of a period
// ---------------------------------------------------------------------------
module param_wave_gen #(
    parameter int W  = 8,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          tick,
    input  logic [2:0]    sel,
    input  logic [PW-1:0] step,
    input  logic [W-1:0]  duty,
    input  logic [W-1:0]  amp,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);

    localparam logic [2:0] SEL_SQUARE = 3'b000;
    localparam logic [2:0] SEL_TRI    = 3'b001;
    localparam logic [2:0] SEL_RAMPUP = 3'b010;
    localparam logic [2:0] SEL_RAMPDN = 3'b011;
    localparam logic [2:0] SEL_RECT   = 3'b100;

    logic [PW-1:0]  phase_r;
    logic [2:0]     sel_r;
    logic [W-1:0]   duty_r;
    logic [W-1:0]   amp_r;

    logic           load_s;
    logic [PW:0]    sum_s;
    logic [W-1:0]   t_s;
    logic [W-1:0]   u_s;
    logic [W-1:0]   raw_s;
    logic [W:0]     amp_p1_s;
    logic [2*W:0]   prod_s;
    logic [W-1:0]   scaled_s;
    logic           unused_prod_s;

    // Accept a new sample when enabled, strobed, and the output slot is free.
    always_comb begin
        load_s = en & tick & (~out_valid | out_ready);
    end

    // Next phase with carry-out; the carry marks the end of a period.
    always_comb begin
        sum_s = {1'b0, phase_r} + {1'b0, step};
    end

    // Waveform shaping from the current phase and the committed mode.
    always_comb begin
        t_s   = phase_r[PW-1 -: W];
        // u is the phase folded at half period: it runs 0..max twice per period.
        u_s   = phase_r[PW-2 -: W];
        raw_s = {W{1'b0}};
        case (sel_r)
            SEL_SQUARE: begin
                if (t_s < duty_r) begin
                    raw_s = {W{1'b1}};
                end else begin
                    raw_s = {W{1'b0}};
                end
            end
            SEL_TRI: begin
                if (phase_r[PW-1]) begin
                    raw_s = ~u_s;
                end else begin
                    raw_s = u_s;
                end
            end
            SEL_RAMPUP: raw_s = t_s;
            SEL_RAMPDN: raw_s = ~t_s;
            SEL_RECT: begin
                if (phase_r[PW-1]) begin
                    raw_s = {W{1'b0}};
                end else begin
                    raw_s = u_s;
                end
            end
            default: raw_s = {W{1'b0}};
        endcase
    end

    // Amplitude scaling: (raw * (amp+1)) >> W, so amp all-ones is unity gain.
    always_comb begin
        amp_p1_s      = {1'b0, amp_r} + {{W{1'b0}}, 1'b1};
        prod_s        = {{(W+1){1'b0}}, raw_s} * {{W{1'b0}}, amp_p1_s};
        scaled_s      = prod_s[2*W-1 -: W];
        // The top bit never sets and the low half is the discarded fraction.
        unused_prod_s = ^{prod_s[2*W], prod_s[W-1:0]};
    end

    // Phase, committed configuration and output handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r   <= {PW{1'b0}};
            sel_r     <= 3'b000;
            duty_r    <= {W{1'b0}};
            amp_r     <= {W{1'b0}};
            out_data  <= {W{1'b0}};
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (clr) begin
            phase_r   <= {PW{1'b0}};
            sel_r     <= sel;
            duty_r    <= duty;
            amp_r     <= amp;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (load_s) begin
                out_data  <= scaled_s;
                out_valid <= 1'b1;
                out_last  <= sum_s[PW];
                phase_r   <= sum_s[PW-1:0];
            end else if (out_valid & out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
            // Config tracks the inputs while disabled, else commits on wrap only.
            if (!en || (load_s && sum_s[PW])) begin
                sel_r  <= sel;
                duty_r <= duty;
                amp_r  <= amp;
            end else begin
                sel_r  <= sel_r;
            end
        end
    end

endmodule
